uart_baud_cfg_ctrl: RTL and testbench

Configuration sequencer for the UART oversampling clock generator. It accepts baud-rate and oversampling-factor requests over a valid/ready handshake and validates them. It computes the clock divisor with a multi-cycle divider, then applies the new settings atomically on an oversampling-tick boundary. It sits between the register/host interface and oversampling_clock_generator, and drives that generator's baud_rate, oversampling_factor and reset inputs.

---
 rtl/uart_cfg_pkg.sv | 40 ++++
 rtl/baud_seq_divider.sv | 63 ++++++
 rtl/uart_baud_cfg_ctrl.sv | 130 +++++++++++++
 tb/tb_uart_baud_cfg_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cfg_pkg.sv
// Shared types, widths and the reset-time divisor helper for uart_baud_cfg_ctrl.
// Build option: UART_BAUD_CFG_ROUND_EN selects round-to-nearest divisors.
package uart_cfg_pkg;

    localparam int unsigned BAUD_W = 32;
    localparam int unsigned OS_W   = 5;
    localparam int unsigned PROD_W = 37;
    localparam int unsigned DIV_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT,
        ST_DIV,
        ST_WAIT_EDGE,
        ST_APPLY
    } cfg_state_t;

    // Elaboration-time divisor, rounded the same way as the runtime divider.
    function automatic logic [DIV_W-1:0] calc_divisor(
        input logic [31:0]       clk_hz,
        input logic [BAUD_W-1:0] baud,
        input logic [OS_W-1:0]   os
    );
        logic [63:0] prod;
        logic [63:0] dvd;
        logic [63:0] quo;
        prod = 64'(baud) * 64'(os);
        if (prod == 64'd0) begin
            return '0;
        end
`ifdef UART_BAUD_CFG_ROUND_EN
        dvd = 64'(clk_hz) + (prod >> 1);
`else
        dvd = 64'(clk_hz);
`endif
        quo = dvd / prod;
        return quo[DIV_W-1:0];
    endfunction

endpackage

// File: rtl/baud_seq_divider.sv
// Iterative restoring divider: 32 quotient bits, one per cycle after start.
// done is asserted during the final step together with the full quotient.
module baud_seq_divider
    import uart_cfg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PROD_W-1:0] dividend,
    input  logic [PROD_W-1:0] divisor,
    output logic              done,
    output logic [DIV_W-1:0]  quotient
);

    logic              running;
    logic [4:0]        step_cnt;
    logic [PROD_W-1:0] rem;
    logic [PROD_W-1:0] dsr;
    logic [DIV_W-1:0]  dvd_sh;
    logic [DIV_W-2:0]  quo;
    logic [PROD_W:0]   trial;
    logic              q_bit;
    logic [PROD_W-1:0] rem_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        trial    = {rem, dvd_sh[DIV_W-1]};
        q_bit    = (trial >= {1'b0, dsr});
        rem_next = q_bit ? PROD_W'(trial - {1'b0, dsr}) : trial[PROD_W-1:0];
    end

    assign done     = running && (step_cnt == 5'd31);
    assign quotient = {quo, q_bit};

    // Dividend bits above bit 31 preload the remainder; the quotient always
    // fits 32 bits, so those upper bits can never produce a quotient bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running  <= 1'b0;
            step_cnt <= '0;
            rem      <= '0;
            dsr      <= '0;
            dvd_sh   <= '0;
            quo      <= '0;
        end else if (start) begin
            running  <= 1'b1;
            step_cnt <= '0;
            rem      <= PROD_W'(dividend[PROD_W-1:DIV_W]);
            dsr      <= divisor;
            dvd_sh   <= dividend[DIV_W-1:0];
            quo      <= '0;
        end else if (running) begin
            rem      <= rem_next;
            dvd_sh   <= {dvd_sh[DIV_W-2:0], 1'b0};
            quo      <= {quo[DIV_W-3:0], q_bit};
            step_cnt <= step_cnt + 5'd1;
            if (step_cnt == 5'd31) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_baud_cfg_ctrl.sv
// UART oversampling-clock configuration sequencer: validates baud/os requests,
// computes CLK_FREQ_HZ/(baud*os) and applies all settings on a tick boundary.
// Build option: UART_BAUD_CFG_ROUND_EN rounds the divisor to nearest.
module uart_baud_cfg_ctrl
    import uart_cfg_pkg::*;
#(
    parameter logic [31:0]       CLK_FREQ_HZ   = 32'd50_000_000,
    parameter logic [BAUD_W-1:0] DEFAULT_BAUD  = 32'd9600,
    parameter logic [OS_W-1:0]   DEFAULT_OS    = 5'd16,
    parameter logic [31:0]       APPLY_TIMEOUT = 32'd1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [BAUD_W-1:0] cfg_baud,
    input  logic [OS_W-1:0]   cfg_os,
    input  logic              os_tick,
    output logic [BAUD_W-1:0] baud_rate_o,
    output logic [OS_W-1:0]   os_factor_o,
    output logic [DIV_W-1:0]  divisor_o,
    output logic              gen_hold,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam logic [DIV_W-1:0] DEFAULT_DIVISOR =
        calc_divisor(CLK_FREQ_HZ, DEFAULT_BAUD, DEFAULT_OS);

    cfg_state_t        state, state_nxt;
    logic [BAUD_W-1:0] baud_sh;
    logic [OS_W-1:0]   os_sh;
    logic [DIV_W-1:0]  div_sh;
    logic [PROD_W-1:0] product;
    logic [PROD_W-1:0] dividend;
    logic [31:0]       wait_cnt;
    logic              tick_prev;
    logic              tick_rise;
    logic              accept;
    logic              req_bad;
    logic              div_done;
    logic [DIV_W-1:0]  div_quot;

    assign cfg_ready = (state == ST_IDLE) && rst;
    assign accept    = cfg_valid && cfg_ready;
    assign req_bad   = (cfg_baud == '0) || (cfg_os == '0);
    assign tick_rise = os_tick && !tick_prev;
    assign product   = PROD_W'(baud_sh) * PROD_W'(os_sh);
`ifdef UART_BAUD_CFG_ROUND_EN
    assign dividend  = PROD_W'(CLK_FREQ_HZ) + (product >> 1);
`else
    assign dividend  = PROD_W'(CLK_FREQ_HZ);
`endif

    baud_seq_divider u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (state == ST_MULT),
        .dividend (dividend),
        .divisor  (product),
        .done     (div_done),
        .quotient (div_quot)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state outputs.
    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        gen_hold  = 1'b0;
        cfg_done  = 1'b0;
        unique case (state)
            ST_IDLE:      if (accept && !req_bad) state_nxt = ST_MULT;
            ST_MULT:      state_nxt = ST_DIV;
            ST_DIV:       if (div_done) state_nxt = (div_quot == '0) ? ST_IDLE : ST_WAIT_EDGE;
            ST_WAIT_EDGE: if (tick_rise || (wait_cnt == APPLY_TIMEOUT)) state_nxt = ST_APPLY;
            ST_APPLY: begin
                gen_hold  = 1'b1;
                cfg_done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Shadow registers, wait counter, tick edge register, error pulse and
    // applied outputs; outputs load on entry to APPLY so they change with cfg_done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_rate_o <= DEFAULT_BAUD;
            os_factor_o <= DEFAULT_OS;
            divisor_o   <= DEFAULT_DIVISOR;
            baud_sh     <= '0;
            os_sh       <= '0;
            div_sh      <= '0;
            wait_cnt    <= '0;
            tick_prev   <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            tick_prev <= os_tick;
            cfg_err   <= (accept && req_bad) ||
                         ((state == ST_DIV) && div_done && (div_quot == '0));
            if (accept && !req_bad) begin
                baud_sh <= cfg_baud;
                os_sh   <= cfg_os;
            end
            if ((state == ST_DIV) && div_done) begin
                div_sh   <= div_quot;
                wait_cnt <= '0;
            end else if (state == ST_WAIT_EDGE) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
            if ((state == ST_WAIT_EDGE) && (state_nxt == ST_APPLY)) begin
                baud_rate_o <= baud_sh;
                os_factor_o <= os_sh;
                divisor_o   <= div_sh;
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_cfg_ctrl.sv
// Self-checking bench for uart_baud_cfg_ctrl: transaction-timeline model plus
// directed and randomized requests.
module tb_uart_baud_cfg_ctrl;

    localparam logic [31:0] CLK_HZ = 32'd50_000_000;
`ifdef UART_BAUD_CFG_ROUND_EN
    localparam logic [31:0] DEF_DIV   = 32'd326;
    localparam logic [31:0] DIV_19200 = 32'd163;
`else
    localparam logic [31:0] DEF_DIV   = 32'd325;
    localparam logic [31:0] DIV_19200 = 32'd162;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        os_tick = 1'b0;
    logic [31:0] cfg_baud = '0;
    logic [4:0]  cfg_os = '0;
    logic        cfg_ready, gen_hold, busy, cfg_done, cfg_err;
    logic [31:0] baud_rate_o, divisor_o;
    logic [4:0]  os_factor_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tick_mode = 0;
    int tick_ph   = 0;

    always #5 clk = ~clk;

    uart_baud_cfg_ctrl #(
        .CLK_FREQ_HZ   (CLK_HZ),
        .DEFAULT_BAUD  (32'd9600),
        .DEFAULT_OS    (5'd16),
        .APPLY_TIMEOUT (32'd1023)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_baud    (cfg_baud),
        .cfg_os      (cfg_os),
        .os_tick     (os_tick),
        .baud_rate_o (baud_rate_o),
        .os_factor_o (os_factor_o),
        .divisor_o   (divisor_o),
        .gen_hold    (gen_hold),
        .busy        (busy),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [31:0] b, input logic [4:0] o);
        longint unsigned p;
        longint unsigned d;
        p = 64'(b) * 64'(o);
`ifdef UART_BAUD_CFG_ROUND_EN
        d = 64'(CLK_HZ) + p / 2;
`else
        d = 64'(CLK_HZ);
`endif
        return 32'(d / p);
    endfunction

    // Oversampling tick source: 0 = held low, 1 = toggles every 8 clk, 2 = random.
    always @(negedge clk) begin
        case (tick_mode)
            1: begin
                tick_ph = (tick_ph + 1) % 16;
                os_tick = (tick_ph >= 8);
            end
            2:       os_tick = 1'($urandom_range(0, 1));
            default: os_tick = 1'b0;
        endcase
    end

    // Model: a request accepted at an edge is age 1 in the following cycle.
    // Age 34 is the first tick-wait cycle (or the error cycle when quotient is 0);
    // apply happens the cycle after a rising tick or after 1024 wait cycles.
    logic        m_busy = 1'b0, m_applied = 1'b0, t_last = 1'b0;
    int          m_age = 0;
    logic [31:0] n_baud = '0, n_q = '0;
    logic [4:0]  n_os = '0;
    logic        e_err = 1'b0, e_done = 1'b0;
    logic [31:0] e_baud = 32'd9600, e_div = DEF_DIV;
    logic [4:0]  e_os = 5'd16;

    always @(posedge clk) begin
        logic rise;
        cyc++;
        rise = os_tick && !t_last;
        if (!rst) begin
            m_busy = 1'b0; m_applied = 1'b0; t_last = 1'b0;
            e_err = 1'b0; e_done = 1'b0;
            e_baud = 32'd9600; e_os = 5'd16; e_div = DEF_DIV;
        end else begin
            t_last = os_tick;
            e_err  = 1'b0;
            e_done = 1'b0;
            if (!m_busy) begin
                if (cfg_valid) begin
                    if (cfg_baud == 0 || cfg_os == 0) begin
                        e_err = 1'b1;
                    end else begin
                        m_busy = 1'b1; m_age = 1; m_applied = 1'b0;
                        n_baud = cfg_baud; n_os = cfg_os; n_q = ref_div(cfg_baud, cfg_os);
                    end
                end
            end else if (m_applied) begin
                m_busy = 1'b0;
            end else begin
                m_age++;
                if (m_age == 34 && n_q == 0) begin
                    e_err = 1'b1;
                    m_busy = 1'b0;
                end else if (m_age >= 35 && (rise || (m_age - 1 == 34 + 1023))) begin
                    e_done = 1'b1; m_applied = 1'b1;
                    e_baud = n_baud; e_os = n_os; e_div = n_q;
                end
            end
        end
        #1;
        chk("cfg_ready", 32'(cfg_ready), 32'(rst && !m_busy));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("cfg_done", 32'(cfg_done), 32'(e_done));
        chk("gen_hold", 32'(gen_hold), 32'(e_done));
        chk("cfg_err", 32'(cfg_err), 32'(e_err));
        chk("baud_rate_o", baud_rate_o, e_baud);
        chk("os_factor_o", 32'(os_factor_o), 32'(e_os));
        chk("divisor_o", divisor_o, e_div);
    end

    // Present a request and hold it until accepted; returns the acceptance cycle.
    task automatic send(input logic [31:0] b, input logic [4:0] o, output int acc);
        int n;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_baud = b; cfg_os = o;
        n = 0;
        while (!cfg_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 3000), 32'd1);
        acc = cyc;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Wait (bounded) for cfg_done or cfg_err; returns at the negedge of that cycle.
    task automatic wait_evt(input int max, output int ev, output logic was_err);
        int n;
        n = 0;
        while (!(cfg_done || cfg_err) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("event_timeout", 32'(n < max), 32'd1);
        ev = cyc;
        was_err = cfg_err;
    endtask

    initial begin
        int   acc, ev, k;
        logic er;
        logic [31:0] tbl [8] = '{32'd300, 32'd1200, 32'd9600, 32'd19200,
                                 32'd57600, 32'd115200, 32'd921600, 32'd4000000};

        chk("model_9600_16", ref_div(32'd9600, 5'd16), DEF_DIV);
        chk("model_115200_16", ref_div(32'd115200, 5'd16), 32'd27);
        chk("model_9600_8", ref_div(32'd9600, 5'd8), 32'd651);
        chk("model_19200_16", ref_div(32'd19200, 5'd16), DIV_19200);

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_baud", baud_rate_o, 32'd9600);
        chk("rst_os", 32'(os_factor_o), 32'd16);
        chk("rst_div", divisor_o, DEF_DIV);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);

        tick_mode = 1;
        send(32'd115200, 5'd16, acc);
        wait_evt(2000, ev, er);
        chk("t1_done", 32'(er), 32'd0);
        chk("t1_latency_min", 32'(ev - acc >= 35), 32'd1);
        chk("t1_div", divisor_o, 32'd27);
        chk("t1_hold_on", 32'(gen_hold), 32'd1);
        @(negedge clk);
        chk("t1_hold_off", 32'(gen_hold), 32'd0);

        tick_mode = 0;
        send(32'd9600, 5'd8, acc);
        wait_evt(1200, ev, er);
        chk("t2_latency", 32'(ev - acc), 32'd1058);
        chk("t2_div", divisor_o, 32'd651);

        tick_mode = 1;
        send(32'd0, 5'd16, acc);
        wait_evt(10, ev, er);
        chk("t3_err", 32'(er), 32'd1);
        chk("t3_div_kept", divisor_o, 32'd651);

        send(32'd4000000, 5'd16, acc);
        wait_evt(200, ev, er);
`ifdef UART_BAUD_CFG_ROUND_EN
        chk("t4_round_done", 32'(er), 32'd0);
        chk("t4_round_div", divisor_o, 32'd1);
`else
        chk("t4_err", 32'(er), 32'd1);
        chk("t4_err_latency", 32'(ev - acc), 32'd34);
        chk("t4_div_kept", divisor_o, 32'd651);
`endif

        send(32'd115200, 5'd16, acc);
        cfg_valid = 1'b1; cfg_baud = 32'd19200; cfg_os = 5'd16;
        chk("t5_backpressure", 32'(cfg_ready), 32'd0);
        wait_evt(200, ev, er);
        chk("t5_first_div", divisor_o, 32'd27);
        send(32'd19200, 5'd16, acc);
        wait_evt(200, ev, er);
        chk("t5_second_div", divisor_o, DIV_19200);

        send(32'd115200, 5'd8, acc);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_baud", baud_rate_o, 32'd9600);
        chk("t6_rst_div", divisor_o, DEF_DIV);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        k = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cfg_done || cfg_err) k++;
        end
        chk("t6_no_event", 32'(k), 32'd0);
        send(32'd19200, 5'd16, acc);
        wait_evt(200, ev, er);
        chk("t6_after_div", divisor_o, DIV_19200);

        tick_mode = 2;
        for (int i = 0; i < 25; i++) begin
            logic [31:0] b;
            logic [4:0]  o;
            case ($urandom_range(0, 5))
                0:       b = $urandom;
                1:       b = 32'd0;
                default: b = tbl[$urandom_range(0, 7)];
            endcase
            o = 5'($urandom_range(0, 31));
            send(b, o, acc);
            wait_evt(1200, ev, er);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
